// File: rtl/wait_fifo_pkg.sv
// Shared widths, byte type and default s_wait threshold for the wait-driven receive FIFO.
package wait_fifo_pkg;

  localparam int DW_DEF    = 8;
  localparam int DEPTH_DEF = 16;

  typedef logic [DW_DEF-1:0] byte_t;

  // Two slots of headroom absorb the write already in flight when s_wait rises.
  function automatic int thresh_default(input int depth);
    return depth - 2;
  endfunction

endpackage

// File: rtl/wait_fifo_mem.sv
// DEPTH x DW register array: one write port, one registered read port (1 clk latency).
// Array contents are not reset; only the read register clears on i_rst.
module wait_fifo_mem #(
  parameter  int DW    = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Holds the last byte when no read is issued.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/wait_fifo_rx.sv
// Receive FIFO with registered s_wait flow control; 1 clk read latency, drops writes when full.
// Define OVF_CNT_EN to add the saturating ovf_cnt dropped-write counter port.
module wait_fifo_rx
  import wait_fifo_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int WAIT_TH = thresh_default(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [DW-1:0]          wr_data,
  output logic                   s_wait,
  input  logic                   enable,
  output logic [DW-1:0]          rd_data,
  output logic                   rd_valid,
  output logic [$clog2(DEPTH):0] count
`ifdef OVF_CNT_EN
  ,
  output logic [7:0]             ovf_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_s_wait;
  logic          r_rd_valid;

  logic          w_full;
  logic          w_empty;
  logic          w_rd_fire;
  logic          w_wr_acc;
  logic [CW-1:0] w_count_next;

  always_comb begin
    w_full       = (r_count == CW'(DEPTH));
    w_empty      = (r_count == '0);
    w_rd_fire    = enable && !w_empty;
    // A read in the same cycle frees the slot, so a full FIFO still accepts.
    w_wr_acc     = wr_en && (!w_full || w_rd_fire);
    w_count_next = r_count + CW'(w_wr_acc) - CW'(w_rd_fire);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_s_wait   <= 1'b1;
      r_rd_valid <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_rd_fire) begin
        r_rptr <= r_rptr + AW'(1);
      end
      r_count    <= w_count_next;
      r_s_wait   <= (w_count_next >= CW'(WAIT_TH));
      r_rd_valid <= w_rd_fire;
    end
  end

  wait_fifo_mem #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_mem (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wptr),
    .i_wr_data (wr_data),
    .i_rd_en   (w_rd_fire),
    .i_rd_addr (r_rptr),
    .o_rd_data (rd_data)
  );

`ifdef OVF_CNT_EN
  logic [7:0] r_ovf_cnt;
  logic       w_drop;

  assign w_drop = wr_en && !w_wr_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf_cnt <= '0;
    end else if (w_drop && (r_ovf_cnt != 8'hFF)) begin
      r_ovf_cnt <= r_ovf_cnt + 8'd1;
    end
  end

  assign ovf_cnt = r_ovf_cnt;
`endif

  assign s_wait   = r_s_wait;
  assign rd_valid = r_rd_valid;
  assign count    = r_count;

endmodule

// File: tb/tb_wait_fifo_rx.sv
// Directed bench for wait_fifo_rx: reset, streaming, backpressure, overflow, simultaneous access, wrap.
module tb_wait_fifo_rx;
  import wait_fifo_pkg::*;

  logic       clk;
  logic       rst;
  logic       wr_en;
  byte_t      wr_data;
  logic       s_wait;
  logic       enable;
  byte_t      rd_data;
  logic       rd_valid;
  logic [4:0] count;
`ifdef OVF_CNT_EN
  logic [7:0] ovf_cnt;
`endif

  int checks;
  int failures;
  byte_t rx_q[$];

  wait_fifo_rx dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .s_wait   (s_wait),
    .enable   (enable),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .count    (count)
`ifdef OVF_CNT_EN
    ,
    .ovf_cnt  (ovf_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    #1;
    if (rd_valid === 1'b1) rx_q.push_back(rd_data);
  end

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; enable = 1'b0; wr_data = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (s_wait !== 1'b1 || count !== 5'd0 || rd_valid !== 1'b0) begin
      $display("FAIL reset_hold: s_wait=%b count=%0d rd_valid=%b, want 1/0/0", s_wait, count, rd_valid);
      failures++;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (s_wait !== 1'b0) begin
      $display("FAIL reset_release: s_wait=%b want 0", s_wait);
      failures++;
    end
    @(negedge clk); wr_en = 1'b1; wr_data = 8'hAA;
    @(negedge clk); wr_data = 8'hBB;
    @(negedge clk); wr_en = 1'b0; enable = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'hAA || count !== 5'd1) begin
      $display("FAIL reset_preload: rd_valid=%b rd_data=%h count=%0d, want 1/aa/1", rd_valid, rd_data, count);
      failures++;
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (rd_valid !== 1'b0 || count !== 5'd0 || s_wait !== 1'b1 || rd_data !== 8'h00) begin
      $display("FAIL reset_async: rd_valid=%b count=%0d s_wait=%b rd_data=%h, want 0/0/1/00",
               rd_valid, count, s_wait, rd_data);
      failures++;
    end
    @(negedge clk); rst = 1'b0; enable = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (s_wait !== 1'b0 || count !== 5'd0) begin
      $display("FAIL reset_rerelease: s_wait=%b count=%0d, want 0/0", s_wait, count);
      failures++;
    end
    rx_q.delete();
  endtask

  task automatic test_stream();
    int    sent;
    logic  do_wr;
    logic  prev_wr;
    byte_t prev_dat;
    sent = 0; prev_wr = 1'b0; prev_dat = '0;
    for (int cyc = 0; cyc < 60 && (sent < 16 || prev_wr); cyc++) begin
      @(negedge clk);
      enable  = 1'b1;
      do_wr   = !s_wait && (sent < 16);
      wr_en   = do_wr;
      wr_data = byte_t'(sent);
      @(posedge clk); #1;
      if (prev_wr) begin
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== prev_dat) begin
          $display("FAIL stream_data: rd_valid=%b rd_data=%h, want 1/%h", rd_valid, rd_data, prev_dat);
          failures++;
        end
      end
      checks++;
      if (count > 5'd1) begin
        $display("FAIL stream_count: count=%0d want <=1", count);
        failures++;
      end
      prev_wr  = do_wr;
      prev_dat = wr_data;
      if (do_wr) sent++;
    end
    @(negedge clk); wr_en = 1'b0;
    checks++;
    if (sent != 16) begin
      $display("FAIL stream_sent: sent=%0d want 16", sent);
      failures++;
    end
    repeat (2) @(posedge clk);
    rx_q.delete();
  endtask

  task automatic test_backpressure();
    int    sent;
    logic  do_wr;
    byte_t got;
    sent = 0;
    rx_q.delete();
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      enable  = 1'b0;
      do_wr   = !s_wait && (sent < 16);
      wr_en   = do_wr;
      wr_data = byte_t'(sent);
      if (do_wr) sent++;
    end
    @(negedge clk); wr_en = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (s_wait !== 1'b1 || count < 5'd14 || count > 5'd15 || int'(count) != sent) begin
      $display("FAIL bp_stall: s_wait=%b count=%0d sent=%0d, want 1 and count 14..15 == sent",
               s_wait, count, sent);
      failures++;
    end
    for (int cyc = 0; cyc < 200 && rx_q.size() < 16; cyc++) begin
      @(negedge clk);
      enable  = 1'b1;
      do_wr   = !s_wait && (sent < 16);
      wr_en   = do_wr;
      wr_data = byte_t'(sent);
      if (do_wr) sent++;
      @(posedge clk); #1;
    end
    @(negedge clk); wr_en = 1'b0;
    repeat (3) @(posedge clk); #1;
    checks++;
    if (rx_q.size() != 16) begin
      $display("FAIL bp_size: got %0d bytes want 16", rx_q.size());
      failures++;
    end
    for (int i = 0; i < 16; i++) begin
      got = 'x;
      if (i < rx_q.size()) got = rx_q[i];
      checks++;
      if (got !== byte_t'(i)) begin
        $display("FAIL bp_order[%0d]: got %h want %h", i, got, byte_t'(i));
        failures++;
      end
    end
  endtask

  task automatic test_overflow();
    byte_t got;
    rx_q.delete();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      enable = 1'b0; wr_en = 1'b1; wr_data = byte_t'(i);
    end
    @(negedge clk); wr_en = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (count !== 5'd16 || s_wait !== 1'b1) begin
      $display("FAIL ovf_full: count=%0d s_wait=%b want 16/1", count, s_wait);
      failures++;
    end
`ifdef OVF_CNT_EN
    checks++;
    if (ovf_cnt !== 8'd4) begin
      $display("FAIL ovf_cnt: got %0d want 4", ovf_cnt);
      failures++;
    end
`endif
    @(negedge clk); enable = 1'b1;
    repeat (20) @(posedge clk); #1;
    checks++;
    if (count !== 5'd0 || s_wait !== 1'b0 || rx_q.size() != 16) begin
      $display("FAIL ovf_drain: count=%0d s_wait=%b bytes=%0d want 0/0/16", count, s_wait, rx_q.size());
      failures++;
    end
    for (int i = 0; i < 16; i++) begin
      got = 'x;
      if (i < rx_q.size()) got = rx_q[i];
      checks++;
      if (got !== byte_t'(i)) begin
        $display("FAIL ovf_order[%0d]: got %h want %h", i, got, byte_t'(i));
        failures++;
      end
    end
  endtask

  task automatic test_simultaneous();
    byte_t got;
    byte_t exp;
    @(negedge clk); enable = 1'b0;
    rx_q.delete();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = byte_t'(8'h40 + i);
      @(negedge clk);
    end
    wr_en = 1'b1; wr_data = 8'h50; enable = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (count !== 5'd16 || rd_valid !== 1'b1 || rd_data !== 8'h40) begin
      $display("FAIL simul_full: count=%0d rd_valid=%b rd_data=%h want 16/1/40", count, rd_valid, rd_data);
      failures++;
    end
    @(negedge clk); wr_en = 1'b0;
    repeat (20) @(posedge clk); #1;
    checks++;
    if (rx_q.size() != 17) begin
      $display("FAIL simul_size: got %0d bytes want 17", rx_q.size());
      failures++;
    end
    for (int i = 0; i < 17; i++) begin
      got = 'x;
      if (i < rx_q.size()) got = rx_q[i];
      exp = byte_t'(8'h40 + i);
      checks++;
      if (got !== exp) begin
        $display("FAIL simul_order[%0d]: got %h want %h", i, got, exp);
        failures++;
      end
    end
`ifdef OVF_CNT_EN
    checks++;
    if (ovf_cnt !== 8'd4) begin
      $display("FAIL simul_ovf: got %0d want 4", ovf_cnt);
      failures++;
    end
`endif
    @(negedge clk); wr_en = 1'b1; wr_data = 8'h77;
    @(posedge clk); #1;
    checks++;
    if (count !== 5'd1 || rd_valid !== 1'b0) begin
      $display("FAIL simul_empty: count=%0d rd_valid=%b want 1/0", count, rd_valid);
      failures++;
    end
    @(negedge clk); wr_en = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h77 || count !== 5'd0) begin
      $display("FAIL simul_empty_next: rd_valid=%b rd_data=%h count=%0d want 1/77/0", rd_valid, rd_data, count);
      failures++;
    end
    @(negedge clk); enable = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_wrap();
    int         sent;
    logic       do_wr;
    logic [4:0] max_cnt;
    byte_t      got;
    sent = 0; max_cnt = '0;
    rx_q.delete();
    for (int cyc = 0; cyc < 600 && rx_q.size() < 40; cyc++) begin
      @(negedge clk);
      enable  = ((cyc / 3) % 2) == 0;
      do_wr   = !s_wait && (sent < 40);
      wr_en   = do_wr;
      wr_data = byte_t'(sent * 7 + 3);
      if (do_wr) sent++;
      @(posedge clk); #1;
      if (count > max_cnt) max_cnt = count;
    end
    @(negedge clk); wr_en = 1'b0; enable = 1'b0;
    repeat (2) @(posedge clk); #1;
    checks++;
    if (rx_q.size() != 40 || max_cnt > 5'd16) begin
      $display("FAIL wrap_size: bytes=%0d max_count=%0d want 40 and <=16", rx_q.size(), max_cnt);
      failures++;
    end
    for (int i = 0; i < 40; i++) begin
      got = 'x;
      if (i < rx_q.size()) got = rx_q[i];
      checks++;
      if (got !== byte_t'(i * 7 + 3)) begin
        $display("FAIL wrap_order[%0d]: got %h want %h", i, got, byte_t'(i * 7 + 3));
        failures++;
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1; wr_en = 1'b0; enable = 1'b0; wr_data = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_overflow();
    test_simultaneous();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
